controlador_de_senha: RTL

//  Sequencer that sits downstream of the 4x4 keypad decoder (decodificador_de_teclado).

---
 rtl/controlador_de_senha_pkg.sv | 23 ++
 rtl/controlador_de_senha_temporizador.sv | 37 +++
 rtl/controlador_de_senha.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/controlador_de_senha_pkg.sv
// Shared key codes, FSM state type and key classification helper for the
// keypad password controller.
package pacote_teclado;

    localparam logic [3:0] TECLA_CONFIRMA = 4'hA;
    localparam logic [3:0] TECLA_APAGA    = 4'hB;
    localparam logic [3:0] TECLA_LIMPA    = 4'hC;
    localparam logic [3:0] TECLA_PROGRAMA = 4'hD;
    localparam logic [3:0] TECLA_NENHUMA  = 4'hF;

    typedef enum logic [2:0] {
        ENTRADA,
        VERIFICAR,
        LIBERADO,
        PROGRAMAR,
        BLOQUEADO
    } estado_senha_t;

    function automatic logic eh_digito(input logic [3:0] tecla);
        return (tecla <= 4'd9);
    endfunction

endpackage

// File: rtl/controlador_de_senha_temporizador.sv
// Loadable down-counter shared by the entry timeout and the lockout timer.
// zero is registered and reflects the count held after each clock edge.
module temporizador #(
    parameter int unsigned LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [LARGURA-1:0] valor,
    input  logic               enable,
    output logic               zero
);

    logic [LARGURA-1:0] contagem;
    logic [LARGURA-1:0] contagem_prox;

    // Load wins over counting; the counter parks at zero.
    always_comb begin
        contagem_prox = contagem;
        if (load) begin
            contagem_prox = valor;
        end else if (enable && (contagem != '0)) begin
            contagem_prox = contagem - LARGURA'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contagem <= '0;
            zero     <= 1'b1;
        end else begin
            contagem <= contagem_prox;
            zero     <= (contagem_prox == '0);
        end
    end

endmodule

// File: rtl/controlador_de_senha.sv
// Password sequencer behind the keypad decoder: builds a BCD code from key
// events, checks it against the stored password, handles lockout and reprogramming.
module controlador_de_senha
    import pacote_teclado::*;
#(
    parameter int unsigned               NUM_DIGITOS     = 4,
    parameter logic [4*NUM_DIGITOS-1:0]  SENHA_PADRAO    = 16'h1234,
    parameter int unsigned               MAX_TENTATIVAS  = 3,
    parameter int unsigned               TEMPO_BLOQUEIO  = 1000,
    parameter int unsigned               TIMEOUT_ENTRADA = 5000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3:0]                         tecla_value,
    input  logic                               tecla_valid,
    output logic                               liberado,
    output logic                               bloqueado,
    output logic                               erro,
    output logic [$clog2(NUM_DIGITOS+1)-1:0]   qtd_digitos,
    output logic [4*NUM_DIGITOS-1:0]           buffer_display
);

    localparam int unsigned LARGURA_BUF  = 4 * NUM_DIGITOS;
    localparam int unsigned LARGURA_QTD  = $clog2(NUM_DIGITOS + 1);
    localparam int unsigned LARGURA_TENT = $clog2(MAX_TENTATIVAS + 1);
    localparam int unsigned TEMPO_MAX    = (TEMPO_BLOQUEIO > TIMEOUT_ENTRADA) ?
                                           TEMPO_BLOQUEIO : TIMEOUT_ENTRADA;
    localparam int unsigned LARGURA_TEMP = $clog2(TEMPO_MAX + 1);

    // Loaded with N-1 so the state lasts exactly N cycles before leaving on zero.
    localparam logic [LARGURA_TEMP-1:0] CARGA_BLOQUEIO = LARGURA_TEMP'(TEMPO_BLOQUEIO - 1);
    localparam logic [LARGURA_TEMP-1:0] CARGA_TIMEOUT  = LARGURA_TEMP'(TIMEOUT_ENTRADA - 1);
    localparam logic [LARGURA_QTD-1:0]  QTD_CHEIA      = LARGURA_QTD'(NUM_DIGITOS);
    localparam logic [LARGURA_TENT-1:0] TENT_MAX       = LARGURA_TENT'(MAX_TENTATIVAS);

    estado_senha_t           estado, estado_prox;
    logic [LARGURA_BUF-1:0]  buffer, buffer_prox, buffer_editado;
    logic [LARGURA_BUF-1:0]  senha, senha_prox;
    logic [LARGURA_QTD-1:0]  qtd, qtd_prox, qtd_editada;
    logic [LARGURA_TENT-1:0] tentativas, tentativas_prox, tentativas_inc;
    logic                    valid_q;
    logic                    evento_c;
    logic                    erro_c;
    logic                    carga_c;
    logic                    habilita_c;
    logic [LARGURA_TEMP-1:0] valor_c;
    logic                    tempo_zerado;

    assign evento_c       = tecla_valid & ~valid_q;
    assign qtd_digitos    = qtd;
    assign buffer_display = buffer;
    assign tentativas_inc = (tentativas < TENT_MAX) ? (tentativas + LARGURA_TENT'(1)) : tentativas;

    temporizador #(
        .LARGURA (LARGURA_TEMP)
    ) u_temporizador (
        .clk    (clk),
        .rst    (rst),
        .load   (carga_c),
        .valor  (valor_c),
        .enable (habilita_c),
        .zero   (tempo_zerado)
    );

    // Digit / backspace / clear editing common to code entry and programming.
    always_comb begin
        buffer_editado = buffer;
        qtd_editada    = qtd;
        if (eh_digito(tecla_value)) begin
            if (qtd < QTD_CHEIA) begin
                buffer_editado = (buffer << 4) | LARGURA_BUF'(tecla_value);
                qtd_editada    = qtd + LARGURA_QTD'(1);
            end
        end else if (tecla_value == TECLA_APAGA) begin
            if (qtd != '0) begin
                buffer_editado = buffer >> 4;
                qtd_editada    = qtd - LARGURA_QTD'(1);
            end
        end else if (tecla_value == TECLA_LIMPA) begin
            buffer_editado = '0;
            qtd_editada    = '0;
        end
    end

    always_comb begin
        estado_prox     = estado;
        buffer_prox     = buffer;
        qtd_prox        = qtd;
        tentativas_prox = tentativas;
        senha_prox      = senha;
        erro_c          = 1'b0;
        carga_c         = 1'b0;
        valor_c         = CARGA_TIMEOUT;
        habilita_c      = 1'b0;

        case (estado)
            ENTRADA: begin
                habilita_c = (qtd != '0);
                if (evento_c) begin
                    carga_c = 1'b1;
                    if (tecla_value == TECLA_CONFIRMA) begin
                        if (qtd == QTD_CHEIA) begin
                            estado_prox = VERIFICAR;
                        end else begin
                            erro_c      = 1'b1;
                            buffer_prox = '0;
                            qtd_prox    = '0;
                        end
                    end else begin
                        buffer_prox = buffer_editado;
                        qtd_prox    = qtd_editada;
                    end
                end else if (tempo_zerado && (qtd != '0)) begin
                    buffer_prox = '0;
                    qtd_prox    = '0;
                end
            end

            VERIFICAR: begin
                buffer_prox = '0;
                qtd_prox    = '0;
                if (buffer == senha) begin
                    estado_prox     = LIBERADO;
                    tentativas_prox = '0;
                end else begin
                    erro_c          = 1'b1;
                    tentativas_prox = tentativas_inc;
                    if (tentativas_inc == TENT_MAX) begin
                        estado_prox = BLOQUEADO;
                        carga_c     = 1'b1;
                        valor_c     = CARGA_BLOQUEIO;
                    end else begin
                        estado_prox = ENTRADA;
                    end
                end
            end

            LIBERADO: begin
                if (evento_c) begin
                    if (tecla_value == TECLA_LIMPA) begin
                        estado_prox = ENTRADA;
                    end else if (tecla_value == TECLA_PROGRAMA) begin
                        estado_prox = PROGRAMAR;
                        buffer_prox = '0;
                        qtd_prox    = '0;
                    end
                end
            end

            PROGRAMAR: begin
                if (evento_c) begin
                    if (tecla_value == TECLA_CONFIRMA) begin
                        buffer_prox = '0;
                        qtd_prox    = '0;
                        if (qtd == QTD_CHEIA) begin
                            senha_prox  = buffer;
                            estado_prox = LIBERADO;
                        end else begin
                            erro_c = 1'b1;
                        end
                    end else if (tecla_value == TECLA_LIMPA) begin
                        estado_prox = LIBERADO;
                        buffer_prox = '0;
                        qtd_prox    = '0;
                    end else begin
                        buffer_prox = buffer_editado;
                        qtd_prox    = qtd_editada;
                    end
                end
            end

            BLOQUEADO: begin
                habilita_c = 1'b1;
                if (tempo_zerado) begin
                    estado_prox     = ENTRADA;
                    tentativas_prox = '0;
                end
            end

            default: begin
                estado_prox = ENTRADA;
            end
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado     <= ENTRADA;
            buffer     <= '0;
            qtd        <= '0;
            tentativas <= '0;
            senha      <= SENHA_PADRAO;
            valid_q    <= 1'b0;
            liberado   <= 1'b0;
            bloqueado  <= 1'b0;
            erro       <= 1'b0;
        end else begin
            estado     <= estado_prox;
            buffer     <= buffer_prox;
            qtd        <= qtd_prox;
            tentativas <= tentativas_prox;
            senha      <= senha_prox;
            valid_q    <= tecla_valid;
            liberado   <= (estado_prox == LIBERADO) || (estado_prox == PROGRAMAR);
            bloqueado  <= (estado_prox == BLOQUEADO);
            erro       <= erro_c;
        end
    end

endmodule
